// File: rtl/conf_mac_pkg.sv
// Shared definitions for the configurable-precision MAC pipeline: FSM encodings,
// default widths, the run-time config payload and the LSB mask helper.
package conf_mac_pkg;

   localparam int unsigned DEF_A_WIDTH   = 24;
   localparam int unsigned DEF_B_WIDTH   = 13;
   localparam int unsigned DEF_ACC_WIDTH = 48;
   localparam int unsigned DEF_OUT_WIDTH = 32;
   localparam int unsigned DEF_OUT_SHIFT = 8;
   localparam int unsigned DEF_CNT_WIDTH = 9;
   localparam int unsigned CUT_A_WIDTH   = 5;
   localparam int unsigned CUT_B_WIDTH   = 4;
   localparam int unsigned MASK_WIDTH    = 64;

   localparam logic [2:0] ST_IDLE  = 3'b000;
   localparam logic [2:0] ST_ACCUM = 3'b001;
   localparam logic [2:0] ST_DRAIN = 3'b010;
   localparam logic [2:0] ST_HOLD  = 3'b011;

   typedef struct packed {
      logic                   apx_en;
      logic [CUT_A_WIDTH-1:0] cut_a;
      logic [CUT_B_WIDTH-1:0] cut_b;
   } mac_cfg_t;

   // Keep-mask with the low 'cut' bits cleared; a cut reaching the width clears everything.
   function automatic logic [MASK_WIDTH-1:0] lsb_clear_mask(input int unsigned width,
                                                            input int unsigned cut);
      logic [MASK_WIDTH-1:0] mask;
      mask = '1;
      if (cut >= width) begin
         mask = '0;
      end else begin
         mask = mask << cut;
      end
      return mask;
   endfunction

endpackage

// File: rtl/conf_mac_opnd_mask.sv
// Combinational operand masking ahead of the first pipeline stage: zeroes the
// requested LSBs of a and b when approximate mode is selected.
module conf_mac_opnd_mask
   import conf_mac_pkg::*;
#(
   parameter int unsigned A_WIDTH = DEF_A_WIDTH,
   parameter int unsigned B_WIDTH = DEF_B_WIDTH
) (
   input  logic [A_WIDTH-1:0]     a,
   input  logic [B_WIDTH-1:0]     b,
   input  logic                   apx_en,
   input  logic [CUT_A_WIDTH-1:0] cut_a,
   input  logic [CUT_B_WIDTH-1:0] cut_b,
   output logic [A_WIDTH-1:0]     a_mask_c,
   output logic [B_WIDTH-1:0]     b_mask_c
);

   logic [A_WIDTH-1:0] keep_a;
   logic [B_WIDTH-1:0] keep_b;

   always_comb begin
      keep_a   = A_WIDTH'(lsb_clear_mask(A_WIDTH, 32'(cut_a)));
      keep_b   = B_WIDTH'(lsb_clear_mask(B_WIDTH, 32'(cut_b)));
      a_mask_c = a;
      b_mask_c = b;
      if (apx_en) begin
         a_mask_c = a & keep_a;
         b_mask_c = b & keep_b;
      end
   end

endmodule

// File: rtl/conf_int_mac_pipe.sv
// Pipelined signed MAC with run-time accurate/approximate operand precision.
// Define CONF_MAC_SAT_EN to clip the output window and report sat_flag.
module conf_int_mac_pipe
   import conf_mac_pkg::*;
#(
   parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
   parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
   parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT,
   parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 racc_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   input  logic                 apx_en,
   input  logic [4:0]           apx_cut_a,
   input  logic [3:0]           apx_cut_b,
   input  logic [CNT_WIDTH-1:0] acc_len,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] p,
   output logic                 sat_flag,
   output logic [2:0]           state_out
);

   localparam int unsigned PROD_WIDTH = A_WIDTH + B_WIDTH;
   localparam int unsigned WIN_MSB    = OUT_SHIFT + OUT_WIDTH - 1;

   logic [2:0]                   state, state_nxt;
   logic                         accept_c;
   logic                         first_c;
   logic [CNT_WIDTH-1:0]         cnt, cnt_inc_c, len_q, len_in_c;
   logic                         drain_cnt;
   mac_cfg_t                     cfg_q, cfg_live_c, cfg_sel_c;
   logic [A_WIDTH-1:0]           a_mask_c;
   logic [B_WIDTH-1:0]           b_mask_c;

   logic                         s1_vld, s1_first, s2_vld, s2_first;
   logic signed [A_WIDTH-1:0]    s1_a;
   logic signed [B_WIDTH-1:0]    s1_b;
   logic signed [PROD_WIDTH-1:0] a_ext_c, b_ext_c, prod_c, s2_prod;
   logic [ACC_WIDTH-1:0]         acc, acc_nxt, prod_ext_c;
   logic [OUT_WIDTH-1:0]         p_c;
   logic                         sat_c;

   assign state_out = state;
   assign accept_c  = in_valid & in_ready;
   assign first_c   = accept_c & (state == ST_IDLE);
   assign cnt_inc_c = CNT_WIDTH'(cnt + CNT_WIDTH'(1));
   assign len_in_c  = (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;

   // The first pair of a burst uses the live config; later pairs use the latched copy.
   always_comb begin
      cfg_live_c.apx_en = apx_en;
      cfg_live_c.cut_a  = apx_cut_a;
      cfg_live_c.cut_b  = apx_cut_b;
      cfg_sel_c         = (state == ST_IDLE) ? cfg_live_c : cfg_q;
   end

   conf_mac_opnd_mask #(
      .A_WIDTH (A_WIDTH),
      .B_WIDTH (B_WIDTH)
   ) u_opnd_mask (
      .a        (a),
      .b        (b),
      .apx_en   (cfg_sel_c.apx_en),
      .cut_a    (cfg_sel_c.cut_a),
      .cut_b    (cfg_sel_c.cut_b),
      .a_mask_c (a_mask_c),
      .b_mask_c (b_mask_c)
   );

   // Burst sequencing.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_nxt = (len_in_c == CNT_WIDTH'(1)) ? ST_DRAIN : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept_c && (cnt_inc_c == len_q)) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (clear) begin
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge racc_n) begin
      if (!racc_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == ST_IDLE) || (state_nxt == ST_ACCUM);
         out_valid <= (state_nxt == ST_HOLD);
      end
   end

   always_comb begin
      a_ext_c    = PROD_WIDTH'(s1_a);
      b_ext_c    = PROD_WIDTH'(s1_b);
      prod_c     = a_ext_c * b_ext_c;
      prod_ext_c = ACC_WIDTH'(s2_prod);
      acc_nxt    = acc;
      if (s2_vld) begin
         acc_nxt = s2_first ? prod_ext_c : ACC_WIDTH'(acc + prod_ext_c);
      end
   end

   // Output window, optionally clipped when the accumulator exceeds its signed range.
   always_comb begin
      p_c   = acc_nxt[WIN_MSB:OUT_SHIFT];
      sat_c = 1'b0;
`ifdef CONF_MAC_SAT_EN
      if (!((&acc_nxt[ACC_WIDTH-1:WIN_MSB]) || !(|acc_nxt[ACC_WIDTH-1:WIN_MSB]))) begin
         sat_c = 1'b1;
         p_c   = acc_nxt[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge racc_n) begin
      if (!racc_n) begin
         cnt       <= '0;
         len_q     <= '0;
         cfg_q     <= '0;
         drain_cnt <= 1'b0;
         s1_vld    <= 1'b0;
         s1_first  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s2_vld    <= 1'b0;
         s2_first  <= 1'b0;
         s2_prod   <= '0;
         acc       <= '0;
         p         <= '0;
         sat_flag  <= 1'b0;
      end else if (clear) begin
         cnt       <= '0;
         drain_cnt <= 1'b0;
         s1_vld    <= 1'b0;
         s1_first  <= 1'b0;
         s2_vld    <= 1'b0;
         s2_first  <= 1'b0;
         acc       <= '0;
      end else begin
         s1_vld   <= accept_c;
         s1_first <= first_c;
         if (accept_c) begin
            s1_a <= a_mask_c;
            s1_b <= b_mask_c;
         end
         s2_vld   <= s1_vld;
         s2_first <= s1_first;
         if (s1_vld) begin
            s2_prod <= prod_c;
         end
         acc <= acc_nxt;
         if (first_c) begin
            cnt   <= CNT_WIDTH'(1);
            len_q <= len_in_c;
            cfg_q <= cfg_live_c;
         end else if (accept_c) begin
            cnt <= cnt_inc_c;
         end
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
         // The final product lands in acc on the same edge the result is captured.
         if ((state == ST_DRAIN) && (state_nxt == ST_HOLD)) begin
            p        <= p_c;
            sat_flag <= sat_c;
         end
      end
   end

endmodule

// File: tb/tb_conf_int_mac_pipe.sv
// Randomized bench for conf_int_mac_pipe against an arithmetic burst model;
// follows CONF_MAC_SAT_EN for the expected clipping behaviour.
module tb_conf_int_mac_pipe;

   localparam int unsigned AW = 24;
   localparam int unsigned BW = 13;
   localparam int unsigned CW = 9;

   logic          clk = 1'b0;
   logic          racc_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] a = '0;
   logic [BW-1:0] b = '0;
   logic          apx_en = 1'b0;
   logic [4:0]    apx_cut_a = '0;
   logic [3:0]    apx_cut_b = '0;
   logic [CW-1:0] acc_len = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   p;
   logic          sat_flag;
   logic [2:0]    state_out;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [31:0]   last_p;
   logic          last_sat;

   always #5 clk = ~clk;

   conf_int_mac_pipe dut (
      .clk       (clk),
      .racc_n    (racc_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .apx_en    (apx_en),
      .apx_cut_a (apx_cut_a),
      .apx_cut_b (apx_cut_b),
      .acc_len   (acc_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .sat_flag  (sat_flag),
      .state_out (state_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint sx(input longint v, input int w);
      return (v >= (64'sd1 <<< (w - 1))) ? v - (64'sd1 <<< w) : v;
   endfunction

   function automatic longint mask_op(input longint v, input int w, input int cut, input bit en);
      if (!en) return v;
      if (cut >= w) return 64'sd0;
      return (v >>> cut) <<< cut;
   endfunction

   // Sum reduced modulo 2^48, windowed from bit 8, clipped or wrapped to 32 bits.
   function automatic void model(input longint sum, output logic [31:0] ep, output logic es);
      longint acc;
      longint win;
      acc = sum & ((64'sd1 <<< 48) - 64'sd1);
      if (acc >= (64'sd1 <<< 47)) acc = acc - (64'sd1 <<< 48);
      win = acc >>> 8;
      es  = 1'b0;
      ep  = 32'(win);
`ifdef CONF_MAC_SAT_EN
      if (win > 64'sd2147483647) begin
         ep = 32'h7FFF_FFFF;
         es = 1'b1;
      end else if (win < -64'sd2147483648) begin
         ep = 32'h8000_0000;
         es = 1'b1;
      end
`endif
   endfunction

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
   endtask

   task automatic burst(input int len_f, input bit en, input int ca, input int cb,
                        input bit rnd, input logic [AW-1:0] a0, input logic [BW-1:0] b0,
                        input int bp, input bit gaps);
      int          n;
      int          k;
      longint      sum;
      logic [31:0] ep;
      logic        es;
      logic [31:0] p_hold;
      logic [AW-1:0] av;
      logic [BW-1:0] bv;
      n   = (len_f == 0) ? 1 : len_f;
      sum = 0;
      for (int i = 0; i < n; i++) begin
         av = rnd ? AW'($urandom) : a0;
         bv = rnd ? BW'($urandom) : b0;
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         a        = av;
         b        = bv;
         in_valid = 1'b1;
         if (i == 0) begin
            apx_en    = en;
            apx_cut_a = 5'(ca);
            apx_cut_b = 4'(cb);
            acc_len   = CW'(len_f);
         end else begin
            apx_en    = 1'($urandom);
            apx_cut_a = 5'($urandom);
            apx_cut_b = 4'($urandom);
            acc_len   = CW'($urandom);
         end
         wait_ready();
         @(negedge clk);
         sum += mask_op(sx(longint'(av), AW), AW, ca, en) * mask_op(sx(longint'(bv), BW), BW, cb, en);
      end
      in_valid = 1'b0;
      check("drain_state", 64'(state_out), 64'd2);
      check("drain_ready", 64'(in_ready), 64'd0);
      k = 1;
      while (!out_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("latency", 64'(k), 64'd3);
      model(sum, ep, es);
      check("result_p", 64'(p), 64'(ep));
      check("result_sat", 64'(sat_flag), 64'(es));
      check("hold_state", 64'(state_out), 64'd3);
      p_hold = p;
      repeat (bp) begin
         in_valid = 1'($urandom);
         a        = AW'($urandom);
         @(negedge clk);
         check("hold_p", 64'(p), 64'(p_hold));
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_state", 64'(state_out), 64'd0);
      check("post_valid", 64'(out_valid), 64'd0);
      check("post_ready", 64'(in_ready), 64'd1);
      last_p   = p_hold;
      last_sat = es;
   endtask

   task automatic abort(input bit use_rst);
      for (int i = 0; i < 3; i++) begin
         a         = AW'($urandom);
         b         = BW'($urandom);
         in_valid  = 1'b1;
         apx_en    = 1'b0;
         acc_len   = CW'(8);
         wait_ready();
         @(negedge clk);
      end
      check("abort_accum", 64'(state_out), 64'd1);
      if (use_rst) begin
         racc_n = 1'b0;
         #2;
         check("rst_ready", 64'(in_ready), 64'd0);
         check("rst_state", 64'(state_out), 64'd0);
         @(negedge clk);
         racc_n   = 1'b1;
         in_valid = 1'b0;
      end else begin
         clear = 1'b1;
         @(negedge clk);
         clear    = 1'b0;
         in_valid = 1'b0;
      end
      check("abort_idle", 64'(state_out), 64'd0);
      repeat (4) @(negedge clk);
      check("abort_valid", 64'(out_valid), 64'd0);
      burst(1, 1'b0, 0, 0, 1'b0, 24'h000100, 13'h001, 0, 1'b0);
      check("abort_next_p", 64'(last_p), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_ready", 64'(in_ready), 64'd0);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_p", 64'(p), 64'd0);
      check("reset_sat", 64'(sat_flag), 64'd0);
      check("reset_state", 64'(state_out), 64'd0);
      racc_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 64'(in_ready), 64'd1);

      burst(1, 1'b0, 0, 0, 1'b0, 24'h000100, 13'h003, 0, 1'b0);
      check("single_p", 64'(last_p), 64'd3);
      burst(1, 1'b1, 8, 0, 1'b0, 24'h0001FF, 13'h003, 0, 1'b0);
      check("apx_p", 64'(last_p), 64'd3);
      burst(1, 1'b0, 8, 0, 1'b0, 24'h0001FF, 13'h003, 0, 1'b0);
      check("acc_p", 64'(last_p), 64'd5);
      burst(2, 1'b0, 0, 0, 1'b0, 24'hFFFF00, 13'h004, 0, 1'b0);
      check("signed_p", 64'(last_p), 64'hFFFF_FFF8);
      burst(256, 1'b0, 0, 0, 1'b0, 24'h7FFFFF, 13'h0FFF, 0, 1'b0);
`ifdef CONF_MAC_SAT_EN
      check("sat_p", 64'(last_p), 64'h7FFF_FFFF);
      check("sat_flag", 64'(last_sat), 64'd1);
`else
      check("wrap_p", 64'(last_p), 64'hFF7F_F001);
      check("wrap_flag", 64'(last_sat), 64'd0);
`endif
      burst(4, 1'b0, 0, 0, 1'b1, '0, '0, 5, 1'b0);
      burst(0, 1'b0, 0, 0, 1'b1, '0, '0, 0, 1'b0);
      burst(3, 1'b1, 30, 15, 1'b1, '0, '0, 1, 1'b0);

      abort(1'b0);
      abort(1'b1);

      for (int t = 0; t < 25; t++) begin
         burst($urandom_range(0, 12), 1'($urandom), $urandom_range(0, 31),
               $urandom_range(0, 15), 1'b1, '0, '0, $urandom_range(0, 3), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
